// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter for the register file write port (we3/wa3/wd3).
// Optional read forwarding of the pending write is enabled with REGFILE_WB_FWD_EN.
module regfile_wb_arbiter #(
    parameter int DW      = 64,
    parameter int AW      = 5,
    parameter int DEPTH   = 2,
    parameter int ZR_ADDR = 31
) (
    input  logic          clk,
    input  logic          reset,
    // Valid/ready: a write transfers on a posedge where x_valid && x_ready.
    // x_ready depends only on FIFO occupancy (and reset), never on x_valid.
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic          we3,
    output logic [AW-1:0] wa3,
    output logic [DW-1:0] wd3,
`ifdef REGFILE_WB_FWD_EN
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    input  logic [DW-1:0] rd1_in,
    input  logic [DW-1:0] rd2_in,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
`endif
    output logic          busy,
    output logic [7:0]    drop_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = AW + DW;
    localparam logic [PW:0]   FULL_CNT = DEPTH[PW:0];
    localparam logic [PW:0]   C_ONE    = 1;
    localparam logic [PW-1:0] P_ONE    = 1;
    localparam logic [AW-1:0] ZR       = ZR_ADDR[AW-1:0];

    logic [EW-1:0] a_mem [DEPTH];
    logic [EW-1:0] b_mem [DEPTH];
    logic [PW-1:0] a_wp, a_rp, b_wp, b_rp;
    logic [PW:0]   a_cnt, b_cnt;
    logic          a_push, b_push, a_pop, b_pop;
    logic          a_ne, b_ne, a_full, b_full;
    logic          rr_favour_b;
    logic          pop;
    logic [EW-1:0] head;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;

    assign a_full  = (a_cnt == FULL_CNT);
    assign b_full  = (b_cnt == FULL_CNT);
    assign a_ne    = (a_cnt != '0);
    assign b_ne    = (b_cnt != '0);
    assign a_ready = reset && !a_full;
    assign b_ready = reset && !b_full;
    assign a_push  = a_valid && a_ready;
    assign b_push  = b_valid && b_ready;

    // Only occupancy registered at the start of the cycle is arbitrated: no fall-through.
    assign a_pop     = a_ne && (!b_ne || !rr_favour_b);
    assign b_pop     = b_ne && !a_pop;
    assign pop       = a_pop || b_pop;
    assign head      = a_pop ? a_mem[a_rp] : b_mem[b_rp];
    assign head_addr = head[EW-1:DW];
    assign head_data = head[DW-1:0];

    assign busy = a_ne || b_ne || we3;

    always_ff @(posedge clk) begin
        if (a_push) a_mem[a_wp] <= {a_addr, a_data};
        if (b_push) b_mem[b_wp] <= {b_addr, b_data};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_wp        <= '0;
            a_rp        <= '0;
            a_cnt       <= '0;
            b_wp        <= '0;
            b_rp        <= '0;
            b_cnt       <= '0;
            rr_favour_b <= 1'b0;
            we3         <= 1'b0;
            wa3         <= '0;
            wd3         <= '0;
            drop_cnt    <= '0;
        end else begin
            if (a_push) a_wp <= a_wp + P_ONE;
            if (a_pop)  a_rp <= a_rp + P_ONE;
            if (b_push) b_wp <= b_wp + P_ONE;
            if (b_pop)  b_rp <= b_rp + P_ONE;

            case ({a_push, a_pop})
                2'b10:   a_cnt <= a_cnt + C_ONE;
                2'b01:   a_cnt <= a_cnt - C_ONE;
                default: a_cnt <= a_cnt;
            endcase
            case ({b_push, b_pop})
                2'b10:   b_cnt <= b_cnt + C_ONE;
                2'b01:   b_cnt <= b_cnt - C_ONE;
                default: b_cnt <= b_cnt;
            endcase

            we3 <= 1'b0;
            if (pop) begin
                // After granting A, the next contested cycle goes to B, and vice versa.
                rr_favour_b <= a_pop;
                if (head_addr != ZR) begin
                    we3 <= 1'b1;
                    wa3 <= head_addr;
                    wd3 <= head_data;
                end else if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

`ifdef REGFILE_WB_FWD_EN
    // Covers a read in the same cycle as the pending register file write.
    assign rd1 = (we3 && (wa3 == ra1)) ? wd3 : rd1_in;
    assign rd2 = (we3 && (wa3 == ra2)) ? wd3 : rd2_in;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: latency, round-robin order, backpressure,
// zero-register drops, reset mid-operation and (with REGFILE_WB_FWD_EN) forwarding.
module tb_regfile_wb_arbiter;

    localparam int DW = 64;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          a_valid = 1'b0, b_valid = 1'b0;
    logic          a_ready, b_ready;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_data = '0, b_data = '0;
    logic          we3, busy;
    logic [AW-1:0] wa3;
    logic [DW-1:0] wd3;
    logic [7:0]    drop_cnt;
`ifdef REGFILE_WB_FWD_EN
    logic [AW-1:0] ra1 = '0, ra2 = '0;
    logic [DW-1:0] rd1_in = '0, rd2_in = '0;
    logic [DW-1:0] rd1, rd2;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [AW+DW-1:0] exp_q[$];

    regfile_wb_arbiter #(.DW(DW), .AW(AW), .DEPTH(2), .ZR_ADDR(31)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .we3(we3), .wa3(wa3), .wd3(wd3),
`ifdef REGFILE_WB_FWD_EN
        .ra1(ra1), .ra2(ra2), .rd1_in(rd1_in), .rd2_in(rd2_in), .rd1(rd1), .rd2(rd2),
`endif
        .busy(busy), .drop_cnt(drop_cnt)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_valid = 1'b0;
        b_valid = 1'b0;
        reset   = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        step();
    endtask

    // Driver tasks
    task automatic drive_a(input logic v, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        a_valid = v;
        a_addr  = ad;
        a_data  = d;
    endtask

    task automatic drive_b(input logic v, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        b_valid = v;
        b_addr  = ad;
        b_data  = d;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        n_vec++; if (we3 !== 1'b0) begin n_err++; $display("FAIL rst_we3 got=%0h exp=0", we3); end
        n_vec++; if (wa3 !== '0) begin n_err++; $display("FAIL rst_wa3 got=%0h exp=0", wa3); end
        n_vec++; if (wd3 !== '0) begin n_err++; $display("FAIL rst_wd3 got=%0h exp=0", wd3); end
        n_vec++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL rst_drop got=%0d exp=0", drop_cnt); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%0h exp=0", busy); end
        n_vec++; if ({a_ready, b_ready} !== 2'b00) begin n_err++; $display("FAIL rst_ready got=%b exp=00", {a_ready, b_ready}); end
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        step();
        n_vec++; if ({a_ready, b_ready} !== 2'b11) begin n_err++; $display("FAIL rel_ready got=%b exp=11", {a_ready, b_ready}); end
        n_vec++; if ({we3, busy} !== 2'b00) begin n_err++; $display("FAIL rel_idle got=%b exp=00", {we3, busy}); end
    endtask

    task automatic test_single_write();
        do_reset();
        drive_a(1'b1, 5'd5, 64'h55);
        step();
        drive_a(1'b0, '0, '0);
        n_vec++; if ({we3, busy} !== 2'b01) begin n_err++; $display("FAIL single_e0 got=%b exp=01", {we3, busy}); end
        step();
        n_vec++; if ({we3, wa3, wd3} !== {1'b1, 5'd5, 64'h55}) begin n_err++; $display("FAIL single_e1 got=%0h/%0d/%0h exp=1/5/55", we3, wa3, wd3); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy got=%0h exp=1", busy); end
        step();
        n_vec++; if ({we3, busy} !== 2'b00) begin n_err++; $display("FAIL single_e2 got=%b exp=00", {we3, busy}); end
        n_vec++; if (wa3 !== 5'd5) begin n_err++; $display("FAIL single_hold got=%0d exp=5", wa3); end
    endtask

    task automatic test_interleave();
        logic [AW+DW-1:0] e;
        do_reset();
        drive_a(1'b1, 5'd1, 64'h11);
        drive_b(1'b1, 5'd3, 64'h33);
        step();
        drive_a(1'b1, 5'd2, 64'h22);
        drive_b(1'b1, 5'd4, 64'h44);
        exp_q.push_back({5'd1, 64'h11});
        exp_q.push_back({5'd3, 64'h33});
        exp_q.push_back({5'd2, 64'h22});
        exp_q.push_back({5'd4, 64'h44});
        n_vec++; if (we3 !== 1'b0) begin n_err++; $display("FAIL ilv_e0 got=%0h exp=0", we3); end
        step();
        drive_a(1'b0, '0, '0);
        drive_b(1'b0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            n_vec++;
            if ({we3, wa3, wd3} !== {1'b1, e}) begin
                n_err++;
                $display("FAIL ilv_%0d got=%0h/%0d/%0h exp=1/%0d/%0h", i, we3, wa3, wd3, e[AW+DW-1:DW], e[DW-1:0]);
            end
            step();
        end
        n_vec++; if ({we3, busy} !== 2'b00) begin n_err++; $display("FAIL ilv_end got=%b exp=00", {we3, busy}); end
    endtask

    task automatic test_backpressure();
        logic          e_we [8];
        logic [AW-1:0] e_wa [8];
        logic [DW-1:0] e_wd [8];
        logic [1:0]    e_rdy [8];
        e_we  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        e_wa  = '{5'd0, 5'd10, 5'd20, 5'd11, 5'd21, 5'd12, 5'd22, 5'd0};
        e_wd  = '{64'h0, 64'hA0, 64'hB0, 64'hA1, 64'hB1, 64'hA2, 64'hB2, 64'h0};
        e_rdy = '{2'b11, 2'b10, 2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            if (k < 3) drive_a(1'b1, AW'(10 + k), DW'(32'hA0 + k));
            else       drive_a(1'b0, '0, '0);
            if (k < 3)       drive_b(1'b1, AW'(20 + k), DW'(32'hB0 + k));
            else if (k == 3) drive_b(1'b1, 5'd22, 64'hB2);
            else             drive_b(1'b0, '0, '0);
            step();
            n_vec++;
            if (we3 !== e_we[k]) begin n_err++; $display("FAIL bp_we_%0d got=%0h exp=%0h", k, we3, e_we[k]); end
            else if (e_we[k] && ({wa3, wd3} !== {e_wa[k], e_wd[k]})) begin
                n_err++;
                $display("FAIL bp_wr_%0d got=%0d/%0h exp=%0d/%0h", k, wa3, wd3, e_wa[k], e_wd[k]);
            end
            n_vec++;
            if ({a_ready, b_ready} !== e_rdy[k]) begin n_err++; $display("FAIL bp_rdy_%0d got=%b exp=%b", k, {a_ready, b_ready}, e_rdy[k]); end
        end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_busy got=%0h exp=0", busy); end
    endtask

    task automatic test_zero_reg();
        do_reset();
        drive_a(1'b1, 5'd31, 64'hFF);
        step();
        drive_a(1'b1, 5'd7, 64'h77);
        n_vec++; if ({we3, drop_cnt} !== 9'd0) begin n_err++; $display("FAIL zr_e0 got=%0h/%0d exp=0/0", we3, drop_cnt); end
        step();
        drive_a(1'b0, '0, '0);
        n_vec++; if ({we3, drop_cnt} !== {1'b0, 8'd1}) begin n_err++; $display("FAIL zr_drop got=%0h/%0d exp=0/1", we3, drop_cnt); end
        n_vec++; if (wa3 !== 5'd0) begin n_err++; $display("FAIL zr_wa3 got=%0d exp=0", wa3); end
        step();
        n_vec++; if ({we3, wa3, wd3} !== {1'b1, 5'd7, 64'h77}) begin n_err++; $display("FAIL zr_next got=%0h/%0d/%0h exp=1/7/77", we3, wa3, wd3); end
        n_vec++; if (drop_cnt !== 8'd1) begin n_err++; $display("FAIL zr_cnt got=%0d exp=1", drop_cnt); end
        step();
        n_vec++; if ({we3, busy} !== 2'b00) begin n_err++; $display("FAIL zr_end got=%b exp=00", {we3, busy}); end
    endtask

    task automatic test_drop_saturate();
        logic saw_we = 1'b0;
        do_reset();
        drive_a(1'b1, 5'd31, 64'h5A);
        for (int k = 1; k <= 300; k++) begin
            step();
            if (we3) saw_we = 1'b1;
            if (k == 255) begin
                n_vec++; if (drop_cnt !== 8'd254) begin n_err++; $display("FAIL sat_254 got=%0d exp=254", drop_cnt); end
            end
            if (k == 256) begin
                n_vec++; if (drop_cnt !== 8'd255) begin n_err++; $display("FAIL sat_255 got=%0d exp=255", drop_cnt); end
            end
        end
        drive_a(1'b0, '0, '0);
        step();
        n_vec++; if (drop_cnt !== 8'd255) begin n_err++; $display("FAIL sat_hold got=%0d exp=255", drop_cnt); end
        n_vec++; if (saw_we !== 1'b0) begin n_err++; $display("FAIL sat_we got=%0h exp=0", saw_we); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive_a(1'b1, 5'd12, 64'h1);
        drive_b(1'b1, 5'd13, 64'h2);
        step();
        drive_a(1'b1, 5'd14, 64'h3);
        drive_b(1'b0, '0, '0);
        step();
        drive_a(1'b0, '0, '0);
        n_vec++; if ({we3, wa3} !== {1'b1, 5'd12}) begin n_err++; $display("FAIL mid_pre got=%0h/%0d exp=1/12", we3, wa3); end
        #2 reset = 1'b0;
        #1;
        n_vec++; if ({we3, busy} !== 2'b00) begin n_err++; $display("FAIL mid_rst got=%b exp=00", {we3, busy}); end
        n_vec++; if ({a_ready, b_ready} !== 2'b00) begin n_err++; $display("FAIL mid_rdy got=%b exp=00", {a_ready, b_ready}); end
        @(posedge clk);
        #3 reset = 1'b1;
        step();
        n_vec++; if ({we3, busy} !== 2'b00) begin n_err++; $display("FAIL mid_stale got=%b exp=00", {we3, busy}); end
        drive_a(1'b1, 5'd2, 64'h22);
        step();
        drive_a(1'b0, '0, '0);
        n_vec++; if (we3 !== 1'b0) begin n_err++; $display("FAIL mid_e0 got=%0h exp=0", we3); end
        step();
        n_vec++; if ({we3, wa3, wd3} !== {1'b1, 5'd2, 64'h22}) begin n_err++; $display("FAIL mid_e1 got=%0h/%0d/%0h exp=1/2/22", we3, wa3, wd3); end
        step();
        n_vec++; if ({we3, busy} !== 2'b00) begin n_err++; $display("FAIL mid_end got=%b exp=00", {we3, busy}); end
    endtask

`ifdef REGFILE_WB_FWD_EN
    task automatic test_fwd();
        do_reset();
        ra1 = 5'd9; rd1_in = 64'h0;
        ra2 = 5'd8; rd2_in = 64'h8;
        drive_a(1'b1, 5'd9, 64'hABC);
        step();
        drive_a(1'b0, '0, '0);
        n_vec++; if (rd1 !== 64'h0) begin n_err++; $display("FAIL fwd_idle got=%0h exp=0", rd1); end
        step();
        n_vec++; if (rd1 !== 64'hABC) begin n_err++; $display("FAIL fwd_rd1 got=%0h exp=abc", rd1); end
        n_vec++; if (rd2 !== 64'h8) begin n_err++; $display("FAIL fwd_rd2 got=%0h exp=8", rd2); end
        ra2 = 5'd9; rd2_in = 64'h7;
        #1;
        n_vec++; if (rd2 !== 64'hABC) begin n_err++; $display("FAIL fwd_rd2_hit got=%0h exp=abc", rd2); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_interleave();
        test_backpressure();
        test_zero_reg();
        test_drop_saturate();
        test_reset_mid();
`ifdef REGFILE_WB_FWD_EN
        test_fwd();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
